cpu_debug_port: RTL and testbench
=================================

// Module: cpu_debug_port
//
// PURPOSE
//   Debug responder attached to cpu_top: accepts run-control and state-read
//   commands on a valid/ready channel and returns one response per command.
//   Lets a bench or host halt, single-step, resume the core and read the PC
//   and register file through a port, without hierarchical peeks.
//   Sits beside cpu_top and drives its halt request and the spare
//   register-file read port.
//
// PARAMETERS
//   XLEN          32  datapath / response width
//   HALT_TIMEOUT  16  cycles to wait for cpu_halted before an error response
//
// PORTS
//   clk           in   1     clock, rising edge
//   rst_n         in   1     asynchronous reset, active-low
//   cmd_valid     in   1     command present
//   cmd_ready     out  1     port can accept a command
//   cmd_op        in   3     0 NOP, 1 HALT, 2 RESUME, 3 STEP, 4 READ_REG,
//                            5 READ_PC, 6-7 reserved
//   cmd_addr      in   5     register index for READ_REG
//   rsp_valid     out  1     response present
//   rsp_ready     in   1     consumer takes the response
//   rsp_data      out  XLEN  response payload
//   rsp_err       out  1     command failed or was illegal
//   cpu_halt_req  out  1     level request for the core to stop retiring
//   cpu_halted    in   1     core is stopped (no retire this cycle)
//   cpu_pc        in   XLEN  current PC of the core
//   rf_raddr      out  5     register-file debug read address
//   rf_rdata      in   XLEN  combinational read data for rf_raddr
//
// BEHAVIOUR
//   Reset values (async on rst_n=0)
//   - State IDLE. cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0,
//     cpu_halt_req=0, rf_raddr=0, timeout counter=0.
//   - Reset mid-command discards the command and drops halt_req, so the core resumes.
//   FSM states: IDLE, RD_REG, WAIT_HALT, STEP_LOW, RESP.
//   - All outputs are registered. cmd_ready=1 only in IDLE. At most one command is outstanding.
//   - Accept in cycle N when cmd_valid&&cmd_ready.
//   - RESP holds rsp_valid, rsp_data and rsp_err stable until rsp_ready=1.
//     -> IDLE on the next edge. cmd_ready=1 in the following cycle.
//   Per-op behaviour (N = accept cycle)
//   - NOP / READ_PC: -> RESP. rsp_valid in N+1.
//     rsp_data = cpu_pc sampled at the N edge for READ_PC, 0 for NOP. err=0.
//   - Reserved op 6/7: -> RESP in N+1 with data=0, err=1. No other side effect.
//   - READ_REG: rf_raddr<=cmd_addr at N -> RD_REG. rsp_data=rf_rdata captured at
//     the N+1 edge. rsp_valid in N+2. cmd_addr=0 returns 0. Legal while running.
//   - HALT: cpu_halt_req<=1 (sticky) -> WAIT_HALT, counter cleared.
//     Each cycle: if cpu_halted -> RESP, data=cpu_pc, err=0.
//     Else counter++; counter==HALT_TIMEOUT -> RESP, data=cpu_pc, err=1.
//     halt_req stays 1 on timeout. Already halted -> rsp_valid in N+2.
//   - RESUME: cpu_halt_req<=0 -> RESP in N+1, data=0, err=0. Idempotent.
//   - STEP: legal only if cpu_halt_req=1 and cpu_halted=1 at accept.
//     Illegal -> RESP in N+1 with err=1; halt_req is unchanged.
//     Legal: cpu_halt_req=0 for exactly one cycle (STEP_LOW), then 1, -> WAIT_HALT.
//     The rest follows the HALT rules. The core contract is one retire per low cycle.
//   - cmd_valid while cmd_ready=0 is ignored; the sender holds it.
//     A simultaneous rsp handshake and cmd_valid does not accept that cycle.
//   - The timeout counter is clog2(HALT_TIMEOUT+1) bits and saturates. It never wraps.
//
// TESTING
//   1 Reset: rst_n=0 mid-WAIT_HALT -> all outputs at reset values; halt_req=0 next edge.
//   2 HALT, core asserts cpu_halted 3 cycles later, pc=0x0000_0008 ->
//     rsp data=0x8, err=0, halt_req stays 1.
//   3 HALT with cpu_halted tied 0 -> rsp err=1 exactly HALT_TIMEOUT cycles after
//     entering WAIT_HALT.
//   4 Halted; STEP -> halt_req low exactly 1 cycle; rsp data=next PC (0x8 -> 0xC), err=0.
//     STEP while running -> err=1.
//   5 Program leaves x1=5, x2=3, x3=8: READ_REG 1/2/3/0 -> 5/3/8/0, each rsp_valid at
//     N+2. Hold rsp_ready=0 4 cycles -> data is stable and cmd_ready=0.
//   6 Back-to-back READ_PC with rsp_ready=1 -> one command every 2 cycles.
//     op 7 -> err=1, data=0.

Source files
------------

// File: rtl/cpu_debug_port.sv
// cpu_debug_port: debug responder beside cpu_top. Accepts one run-control or
// state-read command at a time on a valid/ready channel and returns exactly
// one response per command. Drives the core's halt request and the spare
// register-file read port.
//
// Ports
//   clk, rst_n                   clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only when idle)
//   cmd_op[2:0], cmd_addr[4:0]   0 NOP, 1 HALT, 2 RESUME, 3 STEP, 4 READ_REG,
//                                5 READ_PC, 6-7 reserved (error response)
//   rsp_valid/rsp_ready          response handshake
//   rsp_data[XLEN-1:0], rsp_err  response payload and error flag
//   cpu_halt_req                 level request for the core to stop retiring
//   cpu_halted, cpu_pc           core status and current PC
//   rf_raddr, rf_rdata           debug register-file read port
module cpu_debug_port #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned HALT_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [4:0]      cmd_addr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err,
    output logic            cpu_halt_req,
    input  logic            cpu_halted,
    input  logic [XLEN-1:0] cpu_pc,
    output logic [4:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata
);

    localparam int unsigned CNT_W = $clog2(HALT_TIMEOUT + 1);

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_HALT     = 3'd1;
    localparam logic [2:0] OP_RESUME   = 3'd2;
    localparam logic [2:0] OP_STEP     = 3'd3;
    localparam logic [2:0] OP_READ_REG = 3'd4;
    localparam logic [2:0] OP_READ_PC  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REG,
        S_WAIT_HALT,
        S_STEP_LOW,
        S_RESP
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              cmd_ready_nxt;
    logic              rsp_valid_nxt;
    logic [XLEN-1:0]   rsp_data_nxt;
    logic              rsp_err_nxt;
    logic              halt_req_nxt;
    logic [4:0]        rf_raddr_nxt;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            cmd_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            cpu_halt_req <= 1'b0;
            rf_raddr     <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            cmd_ready    <= cmd_ready_nxt;
            rsp_valid    <= rsp_valid_nxt;
            rsp_data     <= rsp_data_nxt;
            rsp_err      <= rsp_err_nxt;
            cpu_halt_req <= halt_req_nxt;
            rf_raddr     <= rf_raddr_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        cmd_ready_nxt = cmd_ready;
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;
        rsp_err_nxt   = rsp_err;
        halt_req_nxt  = cpu_halt_req;
        rf_raddr_nxt  = rf_raddr;

        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_nxt = 1'b0;
                    case (cmd_op)
                        OP_NOP: begin
                            state_nxt     = S_RESP;
                            rsp_valid_nxt = 1'b1;
                            rsp_data_nxt  = '0;
                            rsp_err_nxt   = 1'b0;
                        end
                        OP_HALT: begin
                            halt_req_nxt = 1'b1;
                            cnt_nxt      = '0;
                            state_nxt    = S_WAIT_HALT;
                        end
                        OP_RESUME: begin
                            halt_req_nxt  = 1'b0;
                            state_nxt     = S_RESP;
                            rsp_valid_nxt = 1'b1;
                            rsp_data_nxt  = '0;
                            rsp_err_nxt   = 1'b0;
                        end
                        OP_STEP: begin
                            // A step only makes sense on a core that is requested and confirmed stopped
                            if (cpu_halt_req && cpu_halted) begin
                                halt_req_nxt = 1'b0;
                                state_nxt    = S_STEP_LOW;
                            end else begin
                                state_nxt     = S_RESP;
                                rsp_valid_nxt = 1'b1;
                                rsp_data_nxt  = '0;
                                rsp_err_nxt   = 1'b1;
                            end
                        end
                        OP_READ_REG: begin
                            rf_raddr_nxt = cmd_addr;
                            state_nxt    = S_RD_REG;
                        end
                        OP_READ_PC: begin
                            state_nxt     = S_RESP;
                            rsp_valid_nxt = 1'b1;
                            rsp_data_nxt  = cpu_pc;
                            rsp_err_nxt   = 1'b0;
                        end
                        default: begin
                            state_nxt     = S_RESP;
                            rsp_valid_nxt = 1'b1;
                            rsp_data_nxt  = '0;
                            rsp_err_nxt   = 1'b1;
                        end
                    endcase
                end
            end

            // rf_raddr became valid this cycle; rf_rdata is combinational
            S_RD_REG: begin
                state_nxt     = S_RESP;
                rsp_valid_nxt = 1'b1;
                rsp_data_nxt  = rf_rdata;
                rsp_err_nxt   = 1'b0;
            end

            // One cycle of released halt request lets the core retire one instruction
            S_STEP_LOW: begin
                halt_req_nxt = 1'b1;
                cnt_nxt      = '0;
                state_nxt    = S_WAIT_HALT;
            end

            // Halt request stays asserted on timeout; only RESUME releases it
            S_WAIT_HALT: begin
                if (cpu_halted) begin
                    state_nxt     = S_RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = cpu_pc;
                    rsp_err_nxt   = 1'b0;
                end else begin
                    if (cnt != CNT_W'(HALT_TIMEOUT)) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                    if (cnt_nxt == CNT_W'(HALT_TIMEOUT)) begin
                        state_nxt     = S_RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_data_nxt  = cpu_pc;
                        rsp_err_nxt   = 1'b1;
                    end
                end
            end

            // Payload held stable until the consumer takes it
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                    state_nxt     = S_IDLE;
                end
            end

            default: begin
                state_nxt     = S_IDLE;
                cmd_ready_nxt = 1'b1;
                rsp_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_debug_port.sv
// Bench for cpu_debug_port: a small behavioural core (PC, halt latency) and a
// register file surround the DUT; each command's expected response, latency
// and halt-request level come from a command-level model of the debug rules.
module tb_cpu_debug_port;

    localparam int unsigned XLEN = 32;
    localparam int unsigned HT   = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [2:0]      cmd_op = 3'd0;
    logic [4:0]      cmd_addr = 5'd0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;
    logic            cpu_halt_req;
    logic            cpu_halted;
    logic [XLEN-1:0] cpu_pc;
    logic [4:0]      rf_raddr;
    logic [XLEN-1:0] rf_rdata;

    cpu_debug_port #(.XLEN(XLEN), .HALT_TIMEOUT(HT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .cpu_halt_req(cpu_halt_req),
        .cpu_halted  (cpu_halted),
        .cpu_pc      (cpu_pc),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata)
    );

    always #5 clk = ~clk;

    // Core: retires one instruction per cycle while the halt request is low,
    // stops retiring as soon as it sees the request, reports halted after halt_lat cycles.
    logic [XLEN-1:0] core_pc = '0;
    logic            core_halted = 1'b0;
    int unsigned     core_dly = 0;
    logic            core_run = 1'b1;
    logic            never_halt = 1'b0;
    logic            pc_set_en = 1'b0;
    logic [XLEN-1:0] pc_set_val = '0;
    int unsigned     halt_lat = 0;

    assign cpu_halted = core_halted;
    assign cpu_pc     = core_pc;

    always @(posedge clk) begin
        if (pc_set_en)
            core_pc <= pc_set_val;
        else if (!cpu_halt_req && core_run)
            core_pc <= core_pc + 32'd4;
        if (!cpu_halt_req) begin
            core_halted <= 1'b0;
            core_dly    <= 0;
        end else if (!never_halt && core_dly >= halt_lat) begin
            core_halted <= 1'b1;
        end else begin
            core_dly <= core_dly + 1;
        end
    end

    logic [XLEN-1:0] rf_m [32];
    assign rf_rdata = (rf_raddr == 5'd0) ? '0 : rf_m[rf_raddr];

    int   n_checks = 0;
    int   n_errors = 0;
    logic halt_req_m = 1'b0;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Issue one command from an idle negedge and check the whole transaction.
    task automatic issue(input logic [2:0] op, input logic [4:0] addr, input int hold,
                         output logic [XLEN-1:0] data_o);
        logic [XLEN-1:0] pc_acc, retire_pc, exp_data;
        logic            exp_err, halted_acc, step_ok, got_rsp;
        int              exp_lat, lat, lows;

        pc_acc     = core_pc;
        halted_acc = core_halted;
        retire_pc  = core_run ? pc_acc + 32'd4 : pc_acc;
        exp_data   = '0;
        exp_err    = 1'b0;
        exp_lat    = 1;
        step_ok    = 1'b0;

        case (op)
            3'd1: begin
                if (halt_req_m && halted_acc) begin
                    exp_lat  = 2;
                    exp_data = pc_acc;
                end else if (never_halt) begin
                    exp_lat  = int'(HT) + 1;
                    exp_data = retire_pc;
                    exp_err  = 1'b1;
                end else begin
                    exp_lat  = int'(halt_lat) + 3;
                    exp_data = retire_pc;
                end
                halt_req_m = 1'b1;
            end
            3'd2: halt_req_m = 1'b0;
            3'd3: begin
                step_ok = halt_req_m && halted_acc;
                if (step_ok) begin
                    exp_lat  = int'(halt_lat) + 4;
                    exp_data = retire_pc;
                end else begin
                    exp_err = 1'b1;
                end
            end
            3'd4: begin
                exp_lat  = 2;
                exp_data = (addr == 5'd0) ? '0 : rf_m[addr];
            end
            3'd5: exp_data = pc_acc;
            3'd6, 3'd7: exp_err = 1'b1;
            default: ;
        endcase

        check("cmd_ready_idle", XLEN'(cmd_ready), XLEN'(1));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        rsp_ready = (hold == 0);
        lat = 0;
        lows = 0;
        got_rsp = 1'b0;
        for (int i = 0; i < 40 && !got_rsp; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            lat++;
            if (!cpu_halt_req) lows++;
            if (rsp_valid) got_rsp = 1'b1;
        end
        check("rsp_seen", XLEN'(got_rsp), XLEN'(1));
        check("rsp_latency", XLEN'(lat), XLEN'(exp_lat));
        check("rsp_data", rsp_data, exp_data);
        check("rsp_err", XLEN'(rsp_err), XLEN'(exp_err));
        data_o = rsp_data;
        if (op == 3'd4) check("rf_raddr", XLEN'(rf_raddr), XLEN'(addr));
        if (op == 3'd3 && step_ok) check("step_low_cycles", XLEN'(lows), XLEN'(1));

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", XLEN'(rsp_valid), XLEN'(1));
            check("hold_data", rsp_data, exp_data);
            check("hold_cmd_ready", XLEN'(cmd_ready), XLEN'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("post_rsp_valid", XLEN'(rsp_valid), XLEN'(0));
        check("post_cmd_ready", XLEN'(cmd_ready), XLEN'(1));
        check("halt_req", XLEN'(cpu_halt_req), XLEN'(halt_req_m));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, XLEN'(cmd_ready), XLEN'(1));
        check({tag, "_rsp_valid"}, XLEN'(rsp_valid), XLEN'(0));
        check({tag, "_rsp_data"}, rsp_data, '0);
        check({tag, "_rsp_err"}, XLEN'(rsp_err), XLEN'(0));
        check({tag, "_halt_req"}, XLEN'(cpu_halt_req), XLEN'(0));
        check({tag, "_rf_raddr"}, XLEN'(rf_raddr), XLEN'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        logic [XLEN-1:0] d;
        logic [XLEN-1:0] pcq[$];
        int acc, rsps, last_acc;

        for (int i = 0; i < 32; i++) rf_m[i] = $urandom;
        rf_m[1] = 32'd5;
        rf_m[2] = 32'd3;
        rf_m[3] = 32'd8;

        // Power-on reset
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a halt wait
        never_halt = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 3'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midwait_halt_req", XLEN'(cpu_halt_req), XLEN'(1));
        check("midwait_rsp_valid", XLEN'(rsp_valid), XLEN'(0));
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(posedge clk);
        #1 check("rst_edge_halt_req", XLEN'(cpu_halt_req), XLEN'(0));
        @(negedge clk);
        rst_n = 1'b1;
        never_halt = 1'b0;
        halt_req_m = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("after_rst_rsp_valid", XLEN'(rsp_valid), XLEN'(0));
        end

        // HALT with the core stopping a few cycles later at PC 0x8
        core_run = 1'b0;
        pc_set_en = 1'b1;
        pc_set_val = 32'h8;
        @(negedge clk);
        pc_set_en = 1'b0;
        halt_lat = 2;
        issue(3'd1, 5'd0, 0, d);
        check("halt_pc", d, 32'h8);

        // STEP from halted: one retire, PC 0x8 -> 0xC
        core_run = 1'b1;
        halt_lat = 0;
        issue(3'd3, 5'd0, 0, d);
        check("step_pc", d, 32'hC);
        issue(3'd2, 5'd0, 0, d);
        issue(3'd2, 5'd0, 0, d);
        issue(3'd3, 5'd0, 0, d);

        // HALT timeout; STEP while requested but not halted is illegal
        never_halt = 1'b1;
        issue(3'd1, 5'd0, 0, d);
        issue(3'd3, 5'd0, 0, d);
        issue(3'd2, 5'd0, 0, d);
        never_halt = 1'b0;

        // Register reads while running, then one held response
        issue(3'd4, 5'd1, 0, d);
        check("x1", d, 32'd5);
        issue(3'd4, 5'd2, 0, d);
        check("x2", d, 32'd3);
        issue(3'd4, 5'd3, 0, d);
        check("x3", d, 32'd8);
        issue(3'd4, 5'd0, 0, d);
        check("x0", d, 32'd0);
        issue(3'd4, 5'd3, 4, d);

        // Back-to-back READ_PC with the consumer always ready
        rsp_ready = 1'b1;
        cmd_op = 3'd5;
        cmd_valid = 1'b1;
        acc = 0;
        rsps = 0;
        last_acc = -1;
        for (int c = 0; c < 40 && (acc < 6 || pcq.size() > 0); c++) begin
            if (acc >= 6) cmd_valid = 1'b0;
            if (rsp_valid) begin
                if (pcq.size() > 0) begin
                    check("b2b_data", rsp_data, pcq.pop_front());
                    check("b2b_err", XLEN'(rsp_err), XLEN'(0));
                    rsps++;
                end else begin
                    check("b2b_unexpected_rsp", XLEN'(rsp_valid), XLEN'(0));
                end
            end
            if (cmd_valid && cmd_ready) begin
                pcq.push_back(core_pc);
                if (last_acc >= 0) check("b2b_gap", XLEN'(c - last_acc), XLEN'(2));
                last_acc = c;
                acc++;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("b2b_rsp_count", XLEN'(rsps), XLEN'(6));

        // Reserved opcodes
        issue(3'd7, 5'd0, 0, d);
        issue(3'd6, 5'd0, 1, d);

        // Randomized command mix
        core_run = 1'b1;
        never_halt = 1'b0;
        for (int k = 0; k < 150; k++) begin
            halt_lat = $urandom_range(0, 3);
            issue(3'($urandom_range(0, 7)), 5'($urandom), int'($urandom_range(0, 2)), d);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
